canal_lock_ctrl: RTL and testbench
==================================

// Module: canal_lock_ctrl
// PURPOSE
// Parametrised two-gate canal lock controller: chamber level, outer/inner gate interlocks, per-side gondola
// approach timers, waiting queues and chamber occupancy. Successor of the single-approach lock block: saturating
// level arithmetic, two approach sides, queue counting and a sticky fault alarm. Sits between the operator
// switch/debounce layer and the status display.
// PARAMETERS
// LEVEL_W        8   width of all level values
// OUTER_LEVEL    73  outer (high) water level; must exceed INNER_LEVEL
// INNER_LEVEL    49  inner (low) water level
// RESET_LEVEL    52  chamber level after reset; INNER_LEVEL..OUTER_LEVEL
// FILL_STEP      2   level increase per fill cycle
// DRAIN_STEP     1   level decrease per drain cycle
// ARRIVE_CYCLES  10  cycles from arrival pulse to gondola waiting at gate (>=2)
// CNT_W          3   width of each waiting-queue counter
// PORTS
// clk             in   1        clock, rising edge
// rst             in   1        asynchronous, active-low reset
// arrive_outer    in   1        1-cycle pulse: gondola approaching outer gate
// arrive_inner    in   1        1-cycle pulse: gondola approaching inner gate
// fill            in   1        level: request chamber fill
// drain           in   1        level: request chamber drain
// outer_open_req  in   1        level: 1 = open outer gate, 0 = close
// inner_open_req  in   1        level: 1 = open inner gate, 0 = close
// gondola_exit    in   1        1-cycle pulse: chamber gondola leaves via far gate
// lock_level      out  LEVEL_W  chamber level
// outer_closed    out  1        1 = outer gate closed
// inner_closed    out  1        1 = inner gate closed
// outer_wait_cnt  out  CNT_W    gondolas waiting at outer gate
// inner_wait_cnt  out  CNT_W    gondolas waiting at inner gate
// outer_busy      out  1        outer approach timer running
// inner_busy      out  1        inner approach timer running
// gondola_inside  out  1        chamber occupied
// alarm           out  1        sticky fault flag
// BEHAVIOUR
// - All outputs registered; input sampled at edge k takes effect at edge k (visible after it).
// - Reset (rst=0, async): lock_level=RESET_LEVEL, both gates closed, wait counts 0, timers idle, busy 0,
//   gondola_inside 0, alarm 0. Reset mid-operation aborts everything; no state survives.
// - Level: only when both gates closed. fill&~drain: level=min(level+FILL_STEP,OUTER_LEVEL); drain&~fill:
//   level=max(level-DRAIN_STEP,INNER_LEVEL); both or neither: hold. Compute in LEVEL_W+1 bits, never wraps.
// - Gates: outer gate follows outer_open_req only while level==OUTER_LEVEL and inner_closed; inner gate follows
//   inner_open_req only while level==INNER_LEVEL and outer_closed; otherwise hold. Level frozen while a gate
//   is open, so closing is always honoured. Both gates open together is unreachable.
// - Approach timer (per side): arrive pulse while idle -> busy=1, count 0..ARRIVE_CYCLES-1; pulse at edge k ->
//   wait_cnt+1 and busy=0 at edge k+ARRIVE_CYCLES. Pulse while busy: dropped, alarm=1.
//   wait_cnt saturates at 2^CNT_W-1; increment at max sets alarm.
// - Admission: chamber empty, side's gate open, side wait_cnt>0 -> gondola_inside=1, wait_cnt-1, entry side
//   latched. Timer expiry and admission on same side same cycle: wait_cnt unchanged.
// - Exit: gondola_exit with gondola_inside and gate opposite entry side open -> gondola_inside=0.
//   Exit pulse otherwise: ignored, alarm=1.
// - alarm cleared only by reset.
// STRUCTURE
// - Package canal_lock_pkg: typedef enum {SIDE_OUTER, SIDE_INNER} side_t; default level constants.
// - Sub-module lock_approach_timer (pulse in, busy, expire pulse, drop pulse), instantiated twice.
// - Top holds level register, gate regs, queue counters, occupancy/entry-side regs, alarm.
// TESTING
// - Reset, fill held 12 cycles -> level 54,56..72,73,73 (saturates, no overshoot); drain held from 73 ->
//   reaches 49 after 24 cycles, then holds.
// - Level 73, outer_open_req=1 -> outer_closed=0 next edge; fill held -> level stays 73;
//   inner_open_req=1 -> inner_closed stays 1.
// - arrive_outer at edge 0 -> outer_busy=1 edges 0..9, outer_wait_cnt=1 at edge 10; second pulse at edge 3 ->
//   dropped, alarm=1, count still 1.
// - Outer open, outer_wait_cnt=1, chamber empty -> next edge gondola_inside=1, count 0; gondola_exit now ->
//   alarm=1, still inside; close, drain to 49, open inner, exit -> gondola_inside=0.
// - CNT_W=3: 8 completed outer arrivals, gate closed -> count 7, alarm=1 on 8th.
// - rst low mid-fill at level 60 with inner timer busy -> immediately level 52, gates closed, busy 0, counts 0.

Source files
------------

// File: rtl/canal_lock_pkg.sv
// Shared definitions for the canal lock controller.
// side_t names the two approach sides of the chamber (outer = high water,
// inner = low water). The DEF_* constants are the default geometry used as
// parameter defaults by canal_lock_ctrl.
package canal_lock_pkg;

    typedef enum logic {
        SIDE_OUTER = 1'b0,
        SIDE_INNER = 1'b1
    } side_t;

    localparam int DEF_LEVEL_W       = 8;
    localparam int DEF_OUTER_LEVEL   = 73;
    localparam int DEF_INNER_LEVEL   = 49;
    localparam int DEF_RESET_LEVEL   = 52;
    localparam int DEF_FILL_STEP     = 2;
    localparam int DEF_DRAIN_STEP    = 1;
    localparam int DEF_ARRIVE_CYCLES = 10;
    localparam int DEF_CNT_W         = 3;

endpackage

// File: rtl/canal_lock_ctrl_timer.sv
// Gondola approach timer for one side of the lock.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-low reset
//   i_pulse   in  arrival pulse
//   o_busy    out timer running (registered)
//   o_expire  out high during the last busy cycle; the gondola reaches the gate
//                 at the coming edge
//   o_drop    out arrival pulse that arrived while the timer was already busy
module lock_approach_timer #(
    parameter int ARRIVE_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    output logic o_busy,
    output logic o_expire,
    output logic o_drop
);

    localparam int CW = (ARRIVE_CYCLES > 1) ? $clog2(ARRIVE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(ARRIVE_CYCLES - 1);

    logic          r_busy;
    logic [CW-1:0] r_count;
    logic          w_expire;

    assign w_expire = r_busy && (r_count == LAST_COUNT);

    // The count runs 0..ARRIVE_CYCLES-1 after the accepting edge, so busy
    // drops exactly ARRIVE_CYCLES edges after the pulse. A pulse that lands
    // while busy (including on the expiry edge) is not restarted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (r_busy) begin
            if (w_expire) begin
                r_busy <= 1'b0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_pulse) begin
            r_busy  <= 1'b1;
            r_count <= '0;
        end
    end

    assign o_busy   = r_busy;
    assign o_expire = w_expire;
    assign o_drop   = i_pulse && r_busy;

endmodule

// File: rtl/canal_lock_ctrl.sv
// Two-gate canal lock controller.
// Ports:
//   clk, rst                        clock / asynchronous active-low reset
//   arrive_outer, arrive_inner      arrival pulses per approach side
//   fill, drain                     chamber level requests (levels)
//   outer_open_req, inner_open_req  gate open(1)/close(0) requests
//   gondola_exit                    chamber gondola leaves via the far gate
//   lock_level                      chamber level
//   outer_closed, inner_closed      gate state, 1 = closed
//   outer_wait_cnt, inner_wait_cnt  gondolas queued at each gate
//   outer_busy, inner_busy          approach timers running
//   gondola_inside                  chamber occupied
//   alarm                           sticky fault, cleared only by reset
module canal_lock_ctrl
    import canal_lock_pkg::*;
#(
    parameter int LEVEL_W       = DEF_LEVEL_W,
    parameter int OUTER_LEVEL   = DEF_OUTER_LEVEL,
    parameter int INNER_LEVEL   = DEF_INNER_LEVEL,
    parameter int RESET_LEVEL   = DEF_RESET_LEVEL,
    parameter int FILL_STEP     = DEF_FILL_STEP,
    parameter int DRAIN_STEP    = DEF_DRAIN_STEP,
    parameter int ARRIVE_CYCLES = DEF_ARRIVE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arrive_outer,
    input  logic               arrive_inner,
    input  logic               fill,
    input  logic               drain,
    input  logic               outer_open_req,
    input  logic               inner_open_req,
    input  logic               gondola_exit,
    output logic [LEVEL_W-1:0] lock_level,
    output logic               outer_closed,
    output logic               inner_closed,
    output logic [CNT_W-1:0]   outer_wait_cnt,
    output logic [CNT_W-1:0]   inner_wait_cnt,
    output logic               outer_busy,
    output logic               inner_busy,
    output logic               gondola_inside,
    output logic               alarm
);

    localparam int LW1 = LEVEL_W + 1;
    localparam logic [LW1-1:0] OUTER_X       = LW1'(OUTER_LEVEL);
    localparam logic [LW1-1:0] INNER_X       = LW1'(INNER_LEVEL);
    localparam logic [LW1-1:0] DRAIN_FLOOR_X = LW1'(INNER_LEVEL + DRAIN_STEP);

    logic [LEVEL_W-1:0] r_level;
    logic               r_outerClosed;
    logic               r_innerClosed;
    logic [CNT_W-1:0]   r_outerCnt;
    logic [CNT_W-1:0]   r_innerCnt;
    logic               r_inside;
    side_t              r_entrySide;
    logic               r_alarm;

    logic               w_outerExpire, w_innerExpire;
    logic               w_outerDrop,   w_innerDrop;
    logic [LW1-1:0]     w_levelExt, w_fillSum;
    logic [LEVEL_W-1:0] w_levelNext;
    logic               w_admitOuter, w_admitInner;
    logic               w_exitOk, w_badExit;
    logic [CNT_W-1:0]   w_outerCntNext, w_innerCntNext;
    logic               w_outerSat, w_innerSat;

    lock_approach_timer #(.ARRIVE_CYCLES(ARRIVE_CYCLES)) u_outerTimer (
        .clk      (clk),
        .rst      (rst),
        .i_pulse  (arrive_outer),
        .o_busy   (outer_busy),
        .o_expire (w_outerExpire),
        .o_drop   (w_outerDrop)
    );

    lock_approach_timer #(.ARRIVE_CYCLES(ARRIVE_CYCLES)) u_innerTimer (
        .clk      (clk),
        .rst      (rst),
        .i_pulse  (arrive_inner),
        .o_busy   (inner_busy),
        .o_expire (w_innerExpire),
        .o_drop   (w_innerDrop)
    );

    // Level arithmetic is one bit wider than the level so the fill sum can
    // never wrap before it is clamped; the drain clamp compares against
    // INNER+STEP so the subtraction is never taken below the floor.
    assign w_levelExt = {1'b0, r_level};
    assign w_fillSum  = w_levelExt + LW1'(FILL_STEP);

    always_comb begin
        w_levelNext = r_level;
        if (r_outerClosed && r_innerClosed) begin
            if (fill && !drain) begin
                w_levelNext = (w_fillSum > OUTER_X) ? OUTER_X[LEVEL_W-1:0]
                                                    : w_fillSum[LEVEL_W-1:0];
            end else if (drain && !fill) begin
                w_levelNext = (w_levelExt < DRAIN_FLOOR_X)
                            ? INNER_X[LEVEL_W-1:0]
                            : LEVEL_W'(w_levelExt - LW1'(DRAIN_STEP));
            end
        end
    end

    // Only one gate can be open at a time, so at most one admission fires.
    assign w_admitOuter = !r_inside && !r_outerClosed && (r_outerCnt != '0);
    assign w_admitInner = !r_inside && !r_innerClosed && (r_innerCnt != '0);

    // A gondola leaves through the gate opposite the one it entered by.
    assign w_exitOk  = gondola_exit && r_inside &&
                       ((r_entrySide == SIDE_OUTER) ? !r_innerClosed : !r_outerClosed);
    assign w_badExit = gondola_exit && !w_exitOk;

    // Queue update: an arrival and an admission on the same edge cancel out;
    // an arrival into a full queue is lost and raises the alarm.
    always_comb begin
        w_outerCntNext = r_outerCnt;
        w_outerSat     = 1'b0;
        if (w_outerExpire && !w_admitOuter) begin
            if (r_outerCnt == '1) w_outerSat = 1'b1;
            else                  w_outerCntNext = r_outerCnt + 1'b1;
        end else if (w_admitOuter && !w_outerExpire) begin
            w_outerCntNext = r_outerCnt - 1'b1;
        end
    end

    always_comb begin
        w_innerCntNext = r_innerCnt;
        w_innerSat     = 1'b0;
        if (w_innerExpire && !w_admitInner) begin
            if (r_innerCnt == '1) w_innerSat = 1'b1;
            else                  w_innerCntNext = r_innerCnt + 1'b1;
        end else if (w_admitInner && !w_innerExpire) begin
            w_innerCntNext = r_innerCnt - 1'b1;
        end
    end

    // Gates only move when the level matches their side and the other gate
    // is shut; the level register is frozen while either gate is open.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level       <= LEVEL_W'(RESET_LEVEL);
            r_outerClosed <= 1'b1;
            r_innerClosed <= 1'b1;
            r_outerCnt    <= '0;
            r_innerCnt    <= '0;
            r_inside      <= 1'b0;
            r_entrySide   <= SIDE_OUTER;
            r_alarm       <= 1'b0;
        end else begin
            r_level    <= w_levelNext;
            r_outerCnt <= w_outerCntNext;
            r_innerCnt <= w_innerCntNext;
            if ((r_level == LEVEL_W'(OUTER_LEVEL)) && r_innerClosed) begin
                r_outerClosed <= !outer_open_req;
            end
            if ((r_level == LEVEL_W'(INNER_LEVEL)) && r_outerClosed) begin
                r_innerClosed <= !inner_open_req;
            end
            if (w_admitOuter) begin
                r_inside    <= 1'b1;
                r_entrySide <= SIDE_OUTER;
            end else if (w_admitInner) begin
                r_inside    <= 1'b1;
                r_entrySide <= SIDE_INNER;
            end else if (w_exitOk) begin
                r_inside <= 1'b0;
            end
            r_alarm <= r_alarm | w_outerDrop | w_innerDrop |
                       w_outerSat | w_innerSat | w_badExit;
        end
    end

    assign lock_level     = r_level;
    assign outer_closed   = r_outerClosed;
    assign inner_closed   = r_innerClosed;
    assign outer_wait_cnt = r_outerCnt;
    assign inner_wait_cnt = r_innerCnt;
    assign gondola_inside = r_inside;
    assign alarm          = r_alarm;

endmodule

// File: tb/tb_canal_lock_ctrl.sv
// Directed testbench for canal_lock_ctrl with default parameters.
module tb_canal_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       arrive_outer, arrive_inner, fill, drain;
   logic       outer_open_req, inner_open_req, gondola_exit;
   logic [7:0] lock_level;
   logic       outer_closed, inner_closed;
   logic [2:0] outer_wait_cnt, inner_wait_cnt;
   logic       outer_busy, inner_busy, gondola_inside, alarm;

   int testsRun = 0;
   int failCount = 0;

   canal_lock_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .arrive_outer   (arrive_outer),
      .arrive_inner   (arrive_inner),
      .fill           (fill),
      .drain          (drain),
      .outer_open_req (outer_open_req),
      .inner_open_req (inner_open_req),
      .gondola_exit   (gondola_exit),
      .lock_level     (lock_level),
      .outer_closed   (outer_closed),
      .inner_closed   (inner_closed),
      .outer_wait_cnt (outer_wait_cnt),
      .inner_wait_cnt (inner_wait_cnt),
      .outer_busy     (outer_busy),
      .inner_busy     (inner_busy),
      .gondola_inside (gondola_inside),
      .alarm          (alarm)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // One comparison point: counts the check and reports a failing one.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive the level inputs and one-cycle pulses, then advance n edges;
   // pulses are withdrawn after the first edge, levels are held.
   task automatic applyStimulus(input logic aOut, input logic aIn, input logic f, input logic d,
                                input logic oReq, input logic iReq, input logic gExit, input int n);
      arrive_outer   = aOut;
      arrive_inner   = aIn;
      fill           = f;
      drain          = d;
      outer_open_req = oReq;
      inner_open_req = iReq;
      gondola_exit   = gExit;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         arrive_outer = 1'b0;
         arrive_inner = 1'b0;
         gondola_exit = 1'b0;
      end
   endtask

   // Pulse reset between edges and leave all inputs idle.
   task automatic doReset();
      arrive_outer = 0; arrive_inner = 0; fill = 0; drain = 0;
      outer_open_req = 0; inner_open_req = 0; gondola_exit = 0;
      rst = 1'b0;
      #3;
      rst = 1'b1;
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      rst = 1'b0;
      arrive_outer = 0; arrive_inner = 0; fill = 0; drain = 0;
      outer_open_req = 0; inner_open_req = 0; gondola_exit = 0;
      #22;
      checkOutput("reset_level", 32'(lock_level), 52);
      checkOutput("reset_outer_closed", 32'(outer_closed), 1);
      checkOutput("reset_inner_closed", 32'(inner_closed), 1);
      checkOutput("reset_outer_cnt", 32'(outer_wait_cnt), 0);
      checkOutput("reset_inner_busy", 32'(inner_busy), 0);
      checkOutput("reset_inside", 32'(gondola_inside), 0);
      checkOutput("reset_alarm", 32'(alarm), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Fill 12 cycles: 54, 56, ..., 72, then clamp at 73.
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(0, 0, 1, 0, 0, 0, 0, 1);
         checkOutput($sformatf("fill_%0d", k), 32'(lock_level), (52 + 2 * k > 73) ? 73 : 52 + 2 * k);
      end

      // Drain 24 cycles to 49, then hold there.
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 23);
      checkOutput("drain_23", 32'(lock_level), 50);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 1);
      checkOutput("drain_24", 32'(lock_level), 49);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 2);
      checkOutput("drain_hold", 32'(lock_level), 49);
      checkOutput("drain_alarm", 32'(alarm), 0);

      // Refill to 73 and exercise the gate interlock.
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 12);
      checkOutput("refill_level", 32'(lock_level), 73);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
      checkOutput("inner_locked_at_high", 32'(inner_closed), 1);
      applyStimulus(0, 0, 1, 0, 1, 0, 0, 1);
      checkOutput("outer_opens", 32'(outer_closed), 0);
      checkOutput("outer_open_level", 32'(lock_level), 73);
      applyStimulus(0, 0, 1, 0, 1, 1, 0, 1);
      checkOutput("inner_stays_closed", 32'(inner_closed), 1);
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 2);
      checkOutput("level_frozen_open", 32'(lock_level), 73);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("outer_closes", 32'(outer_closed), 1);

      // Arrival, admission through the outer gate, bad and good exits.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("adm_busy_e0", 32'(outer_busy), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 9);
      checkOutput("adm_busy_e9", 32'(outer_busy), 1);
      checkOutput("adm_cnt_e9", 32'(outer_wait_cnt), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("adm_cnt_e10", 32'(outer_wait_cnt), 1);
      checkOutput("adm_busy_e10", 32'(outer_busy), 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
      checkOutput("adm_gate_open", 32'(outer_closed), 0);
      checkOutput("adm_not_yet", 32'(gondola_inside), 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
      checkOutput("adm_inside", 32'(gondola_inside), 1);
      checkOutput("adm_cnt_dec", 32'(outer_wait_cnt), 0);
      checkOutput("adm_alarm_clear", 32'(alarm), 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 1);
      checkOutput("bad_exit_alarm", 32'(alarm), 1);
      checkOutput("bad_exit_inside", 32'(gondola_inside), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 24);
      checkOutput("exit_drained", 32'(lock_level), 49);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
      checkOutput("exit_inner_open", 32'(inner_closed), 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
      checkOutput("good_exit", 32'(gondola_inside), 0);

      // Second arrival while the timer runs is dropped.
      doReset();
      checkOutput("rst2_alarm", 32'(alarm), 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 2);
      checkOutput("drop_alarm_before", 32'(alarm), 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("drop_alarm", 32'(alarm), 1);
      checkOutput("drop_busy", 32'(outer_busy), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 6);
      checkOutput("drop_busy_e9", 32'(outer_busy), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("drop_cnt_e10", 32'(outer_wait_cnt), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 10);
      checkOutput("drop_no_second", 32'(outer_wait_cnt), 1);

      // Queue saturation: eight arrivals with the gate closed.
      doReset();
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1, 0, 0, 0, 0, 0, 0, 11);
         checkOutput($sformatf("sat_cnt_%0d", k), 32'(outer_wait_cnt), (k > 7) ? 7 : k);
         checkOutput($sformatf("sat_alarm_%0d", k), 32'(alarm), (k == 8) ? 1 : 0);
      end

      // Reset in the middle of a fill with the inner timer running.
      doReset();
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 3);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 1);
      checkOutput("midrst_level_pre", 32'(lock_level), 60);
      checkOutput("midrst_busy_pre", 32'(inner_busy), 1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midrst_level", 32'(lock_level), 52);
      checkOutput("midrst_busy", 32'(inner_busy), 0);
      checkOutput("midrst_outer_closed", 32'(outer_closed), 1);
      checkOutput("midrst_inner_closed", 32'(inner_closed), 1);
      checkOutput("midrst_cnt", 32'(inner_wait_cnt), 0);
      fill = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
